// File: rtl/mm_sched.sv
// -----------------------------------------------------------------------------
// mm_sched -- sequencer for one systolic matrix-multiply pass.
//
// A command (start + k_len + precision) is validated, then the block:
//   1. streams k_len activation slices from the activation memory into the
//      row FIFOs,
//   2. streams k_len*precision bit-serial weight words from the weight memory
//      into the column FIFOs,
//   3. idles GAP_CYCLES cycles, holds arr_active high for k_len*precision
//      cycles, and
//   4. waits for a rising edge on arr_done (or gives up after TIMEOUT cycles).
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   start/k_len/precision  command strobe and operands (sampled in IDLE only)
//   busy/complete/err/err_code  status (complete and err are 1-cycle pulses)
//   act_rd_*/w_rd_*     operand memory read ports (1-cycle read latency)
//   act_wr_en/act_din, w_wr_en/w_din  FIFO write ports
//   act_afull/w_afull   FIFO almost-full backpressure
//   arr_active/arr_done systolic array handshake
// -----------------------------------------------------------------------------
module mm_sched #(
    parameter int ACT_WIDTH  = 16,
    parameter int N          = 2,
    parameter int K_MAX      = 255,
    parameter int MAX_PREC   = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             k_len,
    input  logic [3:0]             precision,
    output logic                   busy,
    output logic                   complete,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [ADDR_WIDTH-1:0]  act_rd_addr,
    output logic                   act_rd_en,
    input  logic [N*ACT_WIDTH-1:0] act_rd_data,
    output logic [ADDR_WIDTH-1:0]  w_rd_addr,
    output logic                   w_rd_en,
    input  logic [N-1:0]           w_rd_data,
    output logic                   act_wr_en,
    output logic [N*ACT_WIDTH-1:0] act_din,
    input  logic                   act_afull,
    output logic                   w_wr_en,
    output logic [N-1:0]           w_din,
    input  logic                   w_afull,
    output logic                   arr_active,
    input  logic                   arr_done
);

    // k_len (8 bits) * precision (4 bits) fits exactly in 12 bits.
    localparam int CNT_W = 12;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LOAD_ACT,
        S_LOAD_W,
        S_GAP,
        S_RUN,
        S_WAIT
    } state_t;

    state_t           state_q,     state_d;
    logic [7:0]       k_len_q,     k_len_d;
    logic [3:0]       prec_q,      prec_d;
    logic [CNT_W-1:0] rd_cnt_q,    rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q,    wr_cnt_d;
    logic [CNT_W-1:0] seq_cnt_q,   seq_cnt_d;
    logic [TMR_W-1:0] tmr_q,       tmr_d;
    logic             act_wr_q,    act_wr_d;
    logic             w_wr_q,      w_wr_d;
    logic             done_prev_q, done_prev_d;
    logic             complete_q,  complete_d;
    logic             err_q,       err_d;
    logic [1:0]       err_code_q,  err_code_d;

    logic [CNT_W-1:0] k_ext;
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] total_m1;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] limit_m1;
    logic             rd_avail;
    logic             act_rd_fire;
    logic             w_rd_fire;
    logic             k_bad;
    logic             p_bad;
    logic             done_edge;

    assign k_ext    = {4'd0, k_len_q};
    assign total    = k_ext * {8'd0, prec_q};
    assign total_m1 = total - 12'd1;

    // The load phases share one read/write counter pair; only the bound differs.
    assign limit    = (state_q == S_LOAD_ACT) ? k_ext : total;
    assign limit_m1 = limit - 12'd1;
    assign rd_avail = (rd_cnt_q < limit);

    // A read is only issued while the FIFOs report room; the almost-full
    // margin covers the write that lands one cycle later.
    assign act_rd_fire = (state_q == S_LOAD_ACT) && rd_avail && !act_afull;
    assign w_rd_fire   = (state_q == S_LOAD_W)   && rd_avail && !w_afull;

    assign k_bad = (k_len_q == 8'd0) || ({24'd0, k_len_q} > 32'(K_MAX));
    assign p_bad = (prec_q == 4'd0)  || ({28'd0, prec_q}  > 32'(MAX_PREC));

    // done_prev_q tracks arr_done every cycle, so a level that is already
    // high when WAIT is entered never looks like an edge.
    assign done_edge = arr_done && !done_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            k_len_q     <= '0;
            prec_q      <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            seq_cnt_q   <= '0;
            tmr_q       <= '0;
            act_wr_q    <= 1'b0;
            w_wr_q      <= 1'b0;
            done_prev_q <= 1'b0;
            complete_q  <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            prec_q      <= prec_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            seq_cnt_q   <= seq_cnt_d;
            tmr_q       <= tmr_d;
            act_wr_q    <= act_wr_d;
            w_wr_q      <= w_wr_d;
            done_prev_q <= done_prev_d;
            complete_q  <= complete_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        prec_d      = prec_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        seq_cnt_d   = seq_cnt_q;
        tmr_d       = tmr_q;
        err_code_d  = err_code_q;
        complete_d  = 1'b0;
        err_d       = 1'b0;
        act_wr_d    = act_rd_fire;
        w_wr_d      = w_rd_fire;
        done_prev_d = arr_done;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_len_d    = k_len;
                    prec_d     = precision;
                    err_code_d = 2'd0;
                    state_d    = S_CHECK;
                end
            end

            S_CHECK: begin
                rd_cnt_d = '0;
                wr_cnt_d = '0;
                if (k_bad) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd1;
                    state_d    = S_IDLE;
                end else if (p_bad) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_LOAD_ACT;
                end
            end

            S_LOAD_ACT: begin
                if (act_rd_fire) begin
                    rd_cnt_d = rd_cnt_q + 12'd1;
                end
                // Leave only once the final write has landed in the FIFO.
                if (act_wr_q) begin
                    if (wr_cnt_q == limit_m1) begin
                        rd_cnt_d = '0;
                        wr_cnt_d = '0;
                        state_d  = S_LOAD_W;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 12'd1;
                    end
                end
            end

            S_LOAD_W: begin
                if (w_rd_fire) begin
                    rd_cnt_d = rd_cnt_q + 12'd1;
                end
                if (w_wr_q) begin
                    if (wr_cnt_q == limit_m1) begin
                        seq_cnt_d = '0;
                        state_d   = S_GAP;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 12'd1;
                    end
                end
            end

            S_GAP: begin
                if (seq_cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    seq_cnt_d = '0;
                    state_d   = S_RUN;
                end else begin
                    seq_cnt_d = seq_cnt_q + 12'd1;
                end
            end

            S_RUN: begin
                if (seq_cnt_q == total_m1) begin
                    tmr_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    seq_cnt_d = seq_cnt_q + 12'd1;
                end
            end

            S_WAIT: begin
                if (done_edge) begin
                    complete_d = 1'b1;
                    state_d    = S_IDLE;
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd3;
                    state_d    = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pulses are registered alongside the return to IDLE, so busy falls in
    // the same cycle that complete or err is seen.
    assign busy       = (state_q != S_IDLE);
    assign complete   = complete_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign arr_active = (state_q == S_RUN);

    assign act_rd_en   = act_rd_fire;
    assign w_rd_en     = w_rd_fire;
    assign act_rd_addr = (state_q == S_LOAD_ACT) ? ADDR_WIDTH'(rd_cnt_q) : '0;
    assign w_rd_addr   = (state_q == S_LOAD_W)   ? ADDR_WIDTH'(rd_cnt_q) : '0;

    assign act_wr_en = act_wr_q;
    assign w_wr_en   = w_wr_q;

    // Read data is forwarded straight to the FIFOs in the write cycle and is
    // zeroed otherwise so the FIFO data buses stay quiet between writes.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            assign act_din[gi*ACT_WIDTH +: ACT_WIDTH] =
                act_wr_q ? act_rd_data[gi*ACT_WIDTH +: ACT_WIDTH] : '0;
            assign w_din[gi] = w_wr_q ? w_rd_data[gi] : 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_mm_sched.sv
// -----------------------------------------------------------------------------
// tb_mm_sched -- self-checking bench for mm_sched.
// Operand memories are modelled in the bench; expected FIFO writes are queued
// when a command is issued and popped as the DUT writes.
// -----------------------------------------------------------------------------
module tb_mm_sched;

    localparam int ACT_WIDTH  = 16;
    localparam int N          = 2;
    localparam int ADDR_WIDTH = 12;
    localparam int GAP_CYCLES = 2;
    localparam int TIMEOUT    = 1023;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic [7:0]             k_len;
    logic [3:0]             precision;
    logic                   busy;
    logic                   complete;
    logic                   err;
    logic [1:0]             err_code;
    logic [ADDR_WIDTH-1:0]  act_rd_addr;
    logic                   act_rd_en;
    logic [N*ACT_WIDTH-1:0] act_rd_data;
    logic [ADDR_WIDTH-1:0]  w_rd_addr;
    logic                   w_rd_en;
    logic [N-1:0]           w_rd_data;
    logic                   act_wr_en;
    logic [N*ACT_WIDTH-1:0] act_din;
    logic                   act_afull;
    logic                   w_wr_en;
    logic [N-1:0]           w_din;
    logic                   w_afull;
    logic                   arr_active;
    logic                   arr_done;

    mm_sched #(
        .ACT_WIDTH (ACT_WIDTH),
        .N         (N),
        .K_MAX     (255),
        .MAX_PREC  (8),
        .ADDR_WIDTH(ADDR_WIDTH),
        .GAP_CYCLES(GAP_CYCLES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .k_len      (k_len),
        .precision  (precision),
        .busy       (busy),
        .complete   (complete),
        .err        (err),
        .err_code   (err_code),
        .act_rd_addr(act_rd_addr),
        .act_rd_en  (act_rd_en),
        .act_rd_data(act_rd_data),
        .w_rd_addr  (w_rd_addr),
        .w_rd_en    (w_rd_en),
        .w_rd_data  (w_rd_data),
        .act_wr_en  (act_wr_en),
        .act_din    (act_din),
        .act_afull  (act_afull),
        .w_wr_en    (w_wr_en),
        .w_din      (w_din),
        .w_afull    (w_afull),
        .arr_active (arr_active),
        .arr_done   (arr_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- operand memories (1-cycle read latency) ----------------
    logic [N*ACT_WIDTH-1:0] act_mem [0:15];
    logic [N-1:0]           w_mem   [0:63];

    always @(posedge clk) begin
        if (act_rd_en) act_rd_data <= act_mem[act_rd_addr[3:0]];
        if (w_rd_en)   w_rd_data   <= w_mem[w_rd_addr[5:0]];
    end

    // ---------------- checking ----------------
    int tests_run = 0;
    int failures  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard + monitor ----------------
    logic [N*ACT_WIDTH-1:0] act_exp_q [$];
    logic [N-1:0]           w_exp_q   [$];
    int act_exp_total, w_exp_total;
    int act_rd_seen, w_rd_seen, act_addr_exp, w_addr_exp;
    int act_wr_cnt, w_wr_cnt, active_cnt, active_bursts;
    int since_w_wr, gap_obs, complete_cnt;
    bit active_prev;

    task automatic clear_mon();
        act_exp_q.delete();
        w_exp_q.delete();
        act_exp_total = 0;
        w_exp_total   = 0;
        act_rd_seen   = 0;
        w_rd_seen     = 0;
        act_addr_exp  = 0;
        w_addr_exp    = 0;
        act_wr_cnt    = 0;
        w_wr_cnt      = 0;
        active_cnt    = 0;
        active_bursts = 0;
        since_w_wr    = 1000;
        gap_obs       = -1;
        active_prev   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (act_rd_en) begin
                check_val("act_rd_addr", 32'(act_rd_addr), act_addr_exp);
                act_addr_exp++;
                act_rd_seen++;
            end
            if (w_rd_en) begin
                check_val("w_rd_addr", 32'(w_rd_addr), w_addr_exp);
                w_addr_exp++;
                w_rd_seen++;
            end
            if (act_wr_en) begin
                act_wr_cnt++;
                if (act_exp_q.size() == 0) check_val("act_wr_extra", act_wr_cnt, act_exp_total);
                else                       check_val("act_din", act_din, act_exp_q.pop_front());
            end
            if (w_wr_en) begin
                w_wr_cnt++;
                if (w_exp_q.size() == 0) check_val("w_wr_extra", w_wr_cnt, w_exp_total);
                else                     check_val("w_din", 32'(w_din), 32'(w_exp_q.pop_front()));
                since_w_wr = 0;
            end else begin
                since_w_wr++;
            end
            if (arr_active) begin
                if (active_cnt == 0) gap_obs = since_w_wr - 1;
                if (!active_prev) active_bursts++;
                active_cnt++;
            end
            active_prev = arr_active;
            if (complete) begin
                complete_cnt++;
                check_val("cpl_err_excl", 32'(err), 0);
            end
        end
    end

    // ---------------- backpressure driver ----------------
    bit bp_mode    = 1'b0;
    int stall_left = 0;
    bit stall_done = 1'b0;

    initial begin
        act_afull = 1'b0;
        w_afull   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                if (act_rd_seen == 1 && !stall_done) begin
                    stall_left = 3;
                    stall_done = 1'b1;
                end
                act_afull = (stall_left > 0);
                if (stall_left > 0) stall_left--;
                w_afull = ~w_afull;
            end else begin
                act_afull  = 1'b0;
                w_afull    = 1'b0;
                stall_done = 1'b0;
            end
        end
    end

    // ---------------- command helpers ----------------
    task automatic issue_start(input int k, input int p, input bit push);
        clear_mon();
        if (push) begin
            for (int i = 0; i < k; i++)     act_exp_q.push_back(act_mem[i]);
            for (int a = 0; a < k * p; a++) w_exp_q.push_back(w_mem[a]);
            act_exp_total = k;
            w_exp_total   = k * p;
        end
        @(posedge clk);
        #1;
        start     = 1'b1;
        k_len     = 8'(k);
        precision = 4'(p);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check_val("chk_err_code_clr", 32'(err_code), 0);
        check_val("chk_busy", 32'(busy), 1);
        check_val("chk_no_err", 32'(err), 0);
    endtask

    // mode 0: arr_done rises 5 cycles after RUN; 1/2: no edge -> timeout
    task automatic do_pass(input int k, input int p, input int mode, input bit mid_start);
        bit pulsed = 1'b0;
        bit seen   = 1'b0;
        issue_start(k, p, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #2;
            if (mid_start && pulsed && start) begin
                start = 1'b0;
                k_len = 8'(k);
            end
            if (mid_start && !pulsed && w_wr_cnt == 2) begin
                start  = 1'b1;
                k_len  = 8'd1;
                pulsed = 1'b1;
            end
            if (active_cnt > 0 && !arr_active) begin
                seen = 1'b1;
                break;
            end
        end
        check_val("run_finished", 32'(seen), 1);
        check_val("act_wr_count", act_wr_cnt, k);
        check_val("w_wr_count", w_wr_cnt, k * p);
        check_val("active_cycles", active_cnt, k * p);
        check_val("active_bursts", active_bursts, 1);
        check_val("gap_cycles", gap_obs, GAP_CYCLES);
        check_val("act_q_left", act_exp_q.size(), 0);
        check_val("w_q_left", w_exp_q.size(), 0);
        if (mode == 0) begin
            repeat (4) @(posedge clk);
            #1;
            arr_done = 1'b1;
            @(negedge clk);
            check_val("cpl_early", 32'(complete), 0);
            check_val("busy_in_wait", 32'(busy), 1);
            @(negedge clk);
            check_val("cpl_pulse", 32'(complete), 1);
            check_val("cpl_busy_low", 32'(busy), 0);
            check_val("cpl_no_err", 32'(err), 0);
            @(negedge clk);
            check_val("cpl_one_cycle", 32'(complete), 0);
            @(posedge clk);
            #1;
            arr_done = 1'b0;
        end else begin
            repeat (TIMEOUT - 1) @(negedge clk);
            check_val("to_early", 32'(err), 0);
            check_val("to_busy", 32'(busy), 1);
            @(negedge clk);
            check_val("to_err", 32'(err), 1);
            check_val("to_code", 32'(err_code), 3);
            check_val("to_busy_low", 32'(busy), 0);
            check_val("to_no_cpl", 32'(complete), 0);
            @(negedge clk);
            check_val("to_err_pulse", 32'(err), 0);
            check_val("to_code_held", 32'(err_code), 3);
        end
        repeat (3) @(negedge clk);
        $display("[TB] pass k=%0d p=%0d mode=%0d mid_start=%0d bp=%0d: act_wr=%0d w_wr=%0d active=%0d",
                 k, p, mode, mid_start, bp_mode, act_wr_cnt, w_wr_cnt, active_cnt);
    endtask

    task automatic bad_cmd(input int k, input int p, input int code);
        issue_start(k, p, 1'b0);
        @(negedge clk);
        check_val("bad_err", 32'(err), 1);
        check_val("bad_code", 32'(err_code), code);
        check_val("bad_busy_low", 32'(busy), 0);
        @(negedge clk);
        check_val("bad_err_pulse", 32'(err), 0);
        check_val("bad_code_held", 32'(err_code), code);
        check_val("bad_no_reads", act_rd_seen + w_rd_seen, 0);
        $display("[TB] bad command k=%0d p=%0d: err_code=%0d", k, p, err_code);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int cpl_snap;
        bit reached;

        for (int i = 0; i < 16; i++) act_mem[i] = 32'h0101_0000 * 32'(i) + 32'(i * 7 + 1);
        act_mem[0] = 32'h3C00_4000;
        act_mem[1] = 32'hBC00_3800;
        act_mem[2] = 32'h1234_ABCD;
        for (int a = 0; a < 64; a++) w_mem[a] = 2'(a * 3 + (a >> 2));

        rst       = 1'b0;
        start     = 1'b0;
        k_len     = 8'd0;
        precision = 4'd0;
        arr_done  = 1'b0;
        complete_cnt = 0;
        clear_mon();

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_complete", 32'(complete), 0);
        check_val("rst_err", 32'(err), 0);
        check_val("rst_err_code", 32'(err_code), 0);
        check_val("rst_active", 32'(arr_active), 0);
        check_val("rst_strobes", 32'({act_rd_en, w_rd_en, act_wr_en, w_wr_en}), 0);
        check_val("rst_act_din", act_din, 0);
        rst = 1'b1;
        $display("[TB] reset released");

        do_pass(2, 4, 0, 1'b0);
        bp_mode = 1'b1;
        do_pass(2, 4, 0, 1'b0);
        bp_mode = 1'b0;
        do_pass(3, 2, 0, 1'b0);

        bad_cmd(2, 0, 2);
        bad_cmd(0, 4, 1);
        bad_cmd(2, 9, 2);

        do_pass(2, 4, 1, 1'b0);
        arr_done = 1'b1;
        do_pass(2, 4, 2, 1'b0);
        arr_done = 1'b0;

        // Reset during the 4th active cycle.
        issue_start(2, 4, 1'b1);
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (active_cnt == 3) begin
                reached = 1'b1;
                break;
            end
        end
        check_val("rst_run_reached", 32'(reached), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_val("mid_rst_active", 32'(arr_active), 0);
        check_val("mid_rst_busy", 32'(busy), 0);
        check_val("mid_rst_strobes", 32'({act_rd_en, w_rd_en, act_wr_en, w_wr_en}), 0);
        cpl_snap = complete_cnt;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check_val("mid_rst_no_cpl", complete_cnt, cpl_snap);
        check_val("mid_rst_idle", 32'(busy), 0);
        $display("[TB] reset during RUN after %0d active cycles", active_cnt);

        do_pass(2, 4, 0, 1'b0);
        do_pass(2, 4, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
